// File: rtl/move_step_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// move_step_ctrl_pkg
//   Definitions shared by the move playback sequencer and the 7-seg display
//   formatter: 2-bit move codes, the playback FSM state encoding, and a
//   small binary-to-BCD helper for the 1-based step number.
//   No ports (package).
// ---------------------------------------------------------------------------
package move_step_ctrl_pkg;

    // Move codes as packed by the solver, two bits per move.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } move_t;

    // Playback FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the move index / step counters (covers 0..31).
    localparam int STEP_W = 5;

    // Binary (0..31) to two BCD digits {tens, ones}. Playback only ever
    // feeds 0..17, but every input value gives well-formed digits.
    function automatic logic [7:0] to_bcd(input logic [STEP_W-1:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(v - 5'd30);
        end else if (v >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(v - 5'd10);
        end else begin
            tens = 4'd0;
            ones = 4'(v);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/move_step_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, bouncing, asynchronous push-button into a single-cycle
//   press pulse. The button first passes a 2-FF synchronizer; a counter then
//   measures how long the synchronized level has been 1. The pulse fires once
//   the level has been 1 for DEBOUNCE_CYC consecutive cycles after being 0.
//   Releasing the button produces nothing, and holding it produces exactly
//   one pulse.
//
// Parameters
//   DEBOUNCE_CYC  consecutive stable-high cycles required before a press
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous, active-low reset
//   btn    in   raw asynchronous button, active high
//   press  out  registered 1-cycle press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYC);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt holds the number of consecutive high cycles seen so far and
    // saturates at DEBOUNCE_CYC, so a held button can match CNT_LAST only
    // once; any low cycle restarts the measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_FULL) begin
                cnt <= cnt + 1'b1;
            end
            press <= sync2 && (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/move_step_ctrl.sv
// ---------------------------------------------------------------------------
// move_step_ctrl
//   Plays back a solved 8-puzzle move list for the 4-digit 7-seg display.
//   When the solver raises comp, the packed move list and its length are
//   copied into a shadow register; a debounced button press then steps
//   through the moves one at a time. The display formatter receives the
//   current move code, the 1-based step number in BCD and valid/done flags.
//
//   Handshake: comp is a level held high while the solver result is valid.
//   A rising edge of comp (seen in IDLE) captures the list; comp going low
//   returns to IDLE on the next cycle from any state and wins over a press
//   in the same cycle. ord/n_moves are only sampled at that capture.
//
//   Optional feature, macro AUTOPLAY_EN: when defined, an internal counter
//   also advances the step every AUTO_CYC cycles while in SHOW. The counter
//   restarts on SHOW entry and on every press; press and auto pulses are
//   ORed. When undefined, no auto counter exists.
//
// Parameters
//   N_MOVES       max moves in the packed list (ord is 2*N_MOVES bits)
//   DEBOUNCE_CYC  button stable-high cycles before a press is accepted
//   AUTO_CYC      auto-advance period in cycles (AUTOPLAY_EN builds only)
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous, active-low reset
//   comp       in   solver done level
//   ord        in   packed moves, move k at ord[2k+:2], k=0 first
//   n_moves    in   number of valid moves in ord
//   btn        in   raw asynchronous push-button, active high
//   move       out  current move code
//   move_vld   out  move and step outputs are meaningful
//   step_tens  out  BCD tens of the 1-based step number
//   step_ones  out  BCD ones of the 1-based step number
//   done       out  last move has been passed
//   fsm_state  out  playback FSM state (debug observation)
// ---------------------------------------------------------------------------
module move_step_ctrl
    import move_step_ctrl_pkg::*;
#(
    parameter int N_MOVES      = 17,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int AUTO_CYC     = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comp,
    input  logic [2*N_MOVES-1:0]   ord,
    input  logic [STEP_W-1:0]      n_moves,
    input  logic                   btn,
    output logic [1:0]             move,
    output logic                   move_vld,
    output logic [3:0]             step_tens,
    output logic [3:0]             step_ones,
    output logic                   done,
    output logic [1:0]             fsm_state
);

    localparam logic [STEP_W-1:0] LEN_MAX = STEP_W'(N_MOVES);

    state_t               state;
    state_t               state_nx;
    logic                 comp_q;
    logic [2*N_MOVES-1:0] shadow;
    logic [STEP_W-1:0]    len;
    logic [STEP_W-1:0]    idx;
    logic [STEP_W-1:0]    len_cap;
    logic                 press;
    logic                 auto_pulse;
    logic                 step_evt;
    logic                 idx_last;
    logic                 capture;
    logic                 advance;
    logic                 replay;

    // Registered next-output values, built by the output process.
    logic [1:0]           move_d;
    logic                 move_vld_d;
    logic [3:0]           step_tens_d;
    logic [3:0]           step_ones_d;
    logic                 done_d;
    logic [7:0]           bcd;

    // -----------------------------------------------------------------------
    // Button path
    // -----------------------------------------------------------------------
    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    // -----------------------------------------------------------------------
    // Auto-advance
    // -----------------------------------------------------------------------
`ifdef AUTOPLAY_EN
    localparam int AW = $clog2(AUTO_CYC + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYC - 1);

    logic [AW-1:0] auto_cnt;

    // Held at zero outside SHOW, so entering SHOW always starts a full
    // period; any advance in SHOW (press or auto) also restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state != SHOW || press || auto_pulse) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign auto_pulse = (state == SHOW) && (auto_cnt == AUTO_LAST);
`else
    // The period parameter stays on the interface so both builds share one
    // instantiation; it has no logic behind it here.
    logic unused_auto_cfg;
    assign unused_auto_cfg = (AUTO_CYC > 0);
    assign auto_pulse      = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Control decodes
    // -----------------------------------------------------------------------
    assign len_cap  = (n_moves > LEN_MAX) ? LEN_MAX : n_moves;
    assign step_evt = press || auto_pulse;
    assign idx_last = (idx == len - 1'b1);
    assign capture  = (state == IDLE) && comp && !comp_q;
    // comp low blocks every advance, giving it priority over a press.
    assign advance  = (state == SHOW) && comp && step_evt;
    assign replay   = (state == DONE) && comp && press && (len != '0);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (!comp) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!comp_q) begin
                        state_nx = (n_moves == '0) ? DONE : SHOW;
                    end
                end
                SHOW: begin
                    if (step_evt && idx_last) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (press && (len != '0)) begin
                        state_nx = SHOW;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Shadow list, length and move index
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comp_q <= 1'b0;
            shadow <= '0;
            len    <= '0;
            idx    <= '0;
        end else begin
            comp_q <= comp;
            if (capture) begin
                shadow <= ord;
                len    <= len_cap;
                idx    <= '0;
            end else if (advance && !idx_last) begin
                idx <= idx + 1'b1;
            end else if (replay) begin
                idx <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output logic (registered below, so outputs trail state/idx by one
    // cycle)
    // -----------------------------------------------------------------------
    always_comb begin
        move_d      = 2'd0;
        move_vld_d  = 1'b0;
        step_tens_d = 4'd0;
        step_ones_d = 4'd0;
        done_d      = 1'b0;
        bcd         = 8'd0;
        case (state)
            SHOW: begin
                bcd         = to_bcd(idx + 1'b1);
                move_d      = shadow[{idx, 1'b0} +: 2];
                move_vld_d  = 1'b1;
                step_tens_d = bcd[7:4];
                step_ones_d = bcd[3:0];
            end
            DONE: begin
                // Step digits freeze at the list length.
                bcd         = to_bcd(len);
                done_d      = 1'b1;
                step_tens_d = bcd[7:4];
                step_ones_d = bcd[3:0];
            end
            default: begin
                move_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            move      <= 2'd0;
            move_vld  <= 1'b0;
            step_tens <= 4'd0;
            step_ones <= 4'd0;
            done      <= 1'b0;
        end else begin
            move      <= move_d;
            move_vld  <= move_vld_d;
            step_tens <= step_tens_d;
            step_ones <= step_ones_d;
            done      <= done_d;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_move_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_move_step_ctrl
//   Directed bench for move_step_ctrl. Each stimulus pushes the next expected
//   display word {move, move_vld, step_tens, step_ones, done} into exp_q; a
//   monitor forked alongside the driver pops and compares every time the
//   registered outputs change, and flags any change nobody predicted.
// ---------------------------------------------------------------------------
module tb_move_step_ctrl;
    import move_step_ctrl_pkg::*;

    localparam int N_MOVES = 17;
    localparam int DEB_CYC = 4;
    localparam int AUTO_CY = 20;
    localparam int W       = 12;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 comp = 1'b0;
    logic [2*N_MOVES-1:0] ord = '0;
    logic [4:0]           n_moves = '0;
    logic                 btn = 1'b0;
    logic [1:0]           move;
    logic                 move_vld;
    logic [3:0]           step_tens;
    logic [3:0]           step_ones;
    logic                 done;
    logic [1:0]           fsm_state;

    int                   errors = 0;
    int                   checks = 0;
    logic [W-1:0]         exp_q[$];
    logic [W-1:0]         prev_v;
    logic [W-1:0]         mon_cur;
    logic [W-1:0]         mon_exp;
    logic [1:0]           seq_a[8];
    logic [1:0]           seq_b[8];

    move_step_ctrl #(
        .N_MOVES      (N_MOVES),
        .DEBOUNCE_CYC (DEB_CYC),
        .AUTO_CYC     (AUTO_CY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .comp      (comp),
        .ord       (ord),
        .n_moves   (n_moves),
        .btn       (btn),
        .move      (move),
        .move_vld  (move_vld),
        .step_tens (step_tens),
        .step_ones (step_ones),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ex(input logic [1:0] m, input logic v,
                                        input int step, input logic d);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(step / 10);
        o = 4'(step % 10);
        return {m, v, t, o, d};
    endfunction

    function automatic logic [W-1:0] cur_out();
        return {move, move_vld, step_tens, step_ones, done};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: long enough high to pass the debouncer, then released.
    task automatic press_btn();
        btn = 1'b1;
        cycles(DEB_CYC + 8);
        btn = 1'b0;
        cycles(6);
    endtask

    // Wait (bounded) for the monitor to consume every expected word.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d output words still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        cycles(2);
    endtask

    task automatic chk_state(input string name, input logic [1:0] exp_s);
        checks++;
        if (fsm_state !== exp_s) begin
            errors++;
            $display("FAIL %s: state=%0d required %0d", name, fsm_state, exp_s);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver + monitor ----------------
    initial begin
        seq_a = '{RIGHT, LEFT, UP, DOWN, DOWN, RIGHT, UP, LEFT};
        seq_b = '{LEFT, RIGHT, UP, UP, UP, UP, UP, UP};

        // Reset
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_out() !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h required %h", cur_out(), {W{1'b0}});
        end
        chk_state("reset_state", IDLE);
        prev_v = cur_out();

        fork
            forever begin
                @(negedge clk);
                mon_cur = cur_out();
                if (mon_cur !== prev_v) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: got %h, required no change from %h",
                                 mon_cur, prev_v);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_cur !== mon_exp) begin
                            errors++;
                            $display("FAIL out_seq: got %h required %h", mon_cur, mon_exp);
                        end
                    end
                    prev_v = mon_cur;
                end
            end
        join_none

`ifdef AUTOPLAY_EN
        // Auto-advance with no presses: steps 1..3 then DONE, never left.
        ord       = '0;
        ord[1:0]  = UP;
        ord[3:2]  = DOWN;
        ord[5:4]  = LEFT;
        n_moves   = 5'd3;
        exp_q.push_back(ex(UP,   1'b1, 1, 1'b0));
        exp_q.push_back(ex(DOWN, 1'b1, 2, 1'b0));
        exp_q.push_back(ex(LEFT, 1'b1, 3, 1'b0));
        exp_q.push_back(ex(2'd0, 1'b0, 3, 1'b1));
        comp = 1'b1;
        drain("auto_play");
        cycles(3 * AUTO_CY);
        chk_state("auto_stays_done", DONE);
`else
        // 1. Basic playback: UP, DOWN, LEFT
        ord       = '0;
        ord[1:0]  = UP;
        ord[3:2]  = DOWN;
        ord[5:4]  = LEFT;
        n_moves   = 5'd3;
        exp_q.push_back(ex(UP, 1'b1, 1, 1'b0));
        comp = 1'b1;
        drain("t1_capture");
        exp_q.push_back(ex(DOWN, 1'b1, 2, 1'b0));
        press_btn();
        drain("t1_step2");
        exp_q.push_back(ex(LEFT, 1'b1, 3, 1'b0));
        press_btn();
        drain("t1_step3");
        exp_q.push_back(ex(2'd0, 1'b0, 3, 1'b1));
        press_btn();
        drain("t1_done");
        chk_state("t1_state_done", DONE);

        // 2. Replay, then a bouncing press counts once
        exp_q.push_back(ex(UP, 1'b1, 1, 1'b0));
        press_btn();
        drain("t2_replay");
        exp_q.push_back(ex(DOWN, 1'b1, 2, 1'b0));
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            cycles(2);
            btn = 1'b0;
            cycles(2);
        end
        btn = 1'b1;
        cycles(DEB_CYC + 12);
        btn = 1'b0;
        cycles(6);
        drain("t2_bounce");
        cycles(20);

        // 3. Empty list
        exp_q.push_back('0);
        comp = 1'b0;
        drain("t3_comp_low");
        chk_state("t3_state_idle", IDLE);
        n_moves = 5'd0;
        exp_q.push_back(ex(2'd0, 1'b0, 0, 1'b1));
        comp = 1'b1;
        drain("t3_empty_done");
        press_btn();
        cycles(20);
        chk_state("t3_press_stays_done", DONE);

        // 4. Abort mid-SHOW at step 05, recapture, shadow ignores ord changes
        exp_q.push_back('0);
        comp = 1'b0;
        drain("t4_idle");
        for (int k = 0; k < 8; k++) ord[2*k +: 2] = seq_a[k];
        n_moves = 5'd8;
        exp_q.push_back(ex(seq_a[0], 1'b1, 1, 1'b0));
        comp = 1'b1;
        drain("t4_capture");
        for (int k = 1; k < 5; k++) begin
            exp_q.push_back(ex(seq_a[k], 1'b1, k + 1, 1'b0));
            press_btn();
            drain("t4_step");
        end
        exp_q.push_back('0);
        comp = 1'b0;
        @(negedge clk);
        chk_state("t4_abort_next_cycle", IDLE);
        drain("t4_abort_out");
        for (int k = 0; k < 8; k++) ord[2*k +: 2] = seq_b[k];
        exp_q.push_back(ex(seq_b[0], 1'b1, 1, 1'b0));
        comp = 1'b1;
        drain("t4_recapture");
        for (int k = 0; k < 8; k++) ord[2*k +: 2] = seq_a[k];
        n_moves = 5'd2;
        cycles(20);
        exp_q.push_back(ex(seq_b[1], 1'b1, 2, 1'b0));
        press_btn();
        drain("t4_shadow_used");

        // 5. Full 17-move list, done, replay
        exp_q.push_back('0);
        comp = 1'b0;
        drain("t5_idle");
        for (int k = 0; k < N_MOVES; k++) ord[2*k +: 2] = 2'(k % 4);
        n_moves = 5'd17;
        exp_q.push_back(ex(2'd0, 1'b1, 1, 1'b0));
        comp = 1'b1;
        drain("t5_capture");
        for (int k = 1; k < N_MOVES; k++) begin
            exp_q.push_back(ex(2'(k % 4), 1'b1, k + 1, 1'b0));
            press_btn();
            drain("t5_step");
        end
        exp_q.push_back(ex(2'd0, 1'b0, 17, 1'b1));
        press_btn();
        drain("t5_done");
        chk_state("t5_state_done", DONE);
        exp_q.push_back(ex(2'd0, 1'b1, 1, 1'b0));
        press_btn();
        drain("t5_replay");

        // 6. Reset at step 07
        for (int k = 1; k < 7; k++) begin
            exp_q.push_back(ex(2'(k % 4), 1'b1, k + 1, 1'b0));
            press_btn();
            drain("t6_step");
        end
        exp_q.push_back('0);
        rst_n = 1'b0;
        comp  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_state("t6_reset_state", IDLE);
        drain("t6_reset_out");

        // Length above N_MOVES saturates at capture
        for (int k = 0; k < N_MOVES; k++) ord[2*k +: 2] = 2'(3 - (k % 4));
        n_moves = 5'd25;
        exp_q.push_back(ex(2'd3, 1'b1, 1, 1'b0));
        comp = 1'b1;
        drain("sat_capture");
        for (int k = 1; k < N_MOVES; k++) begin
            exp_q.push_back(ex(2'(3 - (k % 4)), 1'b1, k + 1, 1'b0));
            press_btn();
            drain("sat_step");
        end
        exp_q.push_back(ex(2'd0, 1'b0, 17, 1'b1));
        press_btn();
        drain("sat_done");
        exp_q.push_back('0);
        comp = 1'b0;
        drain("final_idle");
`endif

        cycles(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
